display_scanner: RTL and testbench

// - Raster scan-out stage downstream of the game plate. Generates VGA-class timing.
// - Walks the board cell by cell on the game plate display port (dis_logic_x/y).
// - Converts the returned matrix/current-tile bits into 12-bit RGB pixels.
// - Also draws a board border and a 4x4 next-block preview; sits between game plate and video DAC/pins.

---
 rtl/display_scanner_pkg.sv | 27 ++
 rtl/display_scanner_raster_timing.sv | 81 ++++++++
 rtl/display_scanner.sv | 173 +++++++++++++++++
 tb/tb_display_scanner.sv | 138 +++++++++++++
 4 files changed

// File: rtl/display_scanner_pkg.sv
// Shared colours, region codes and the per-pixel pipeline record for the display scanner.
package display_scanner_pkg;

    localparam logic [11:0] COLOR_TILE   = 12'hF80;
    localparam logic [11:0] COLOR_MM     = 12'h0AF;
    localparam logic [11:0] COLOR_LOSE   = 12'hF00;
    localparam logic [11:0] COLOR_EMPTY  = 12'h111;
    localparam logic [11:0] COLOR_BORDER = 12'hFFF;
    localparam logic [11:0] COLOR_PREV   = 12'h0F0;
    localparam logic [11:0] COLOR_GRID   = 12'h333;
    localparam logic [11:0] COLOR_BLANK  = 12'h000;

    typedef enum logic [1:0] {eRegNone, eRegBoard, eRegBorder, eRegPreview} region_e;

    typedef struct packed {
        region_e region;
        logic    hsync;
        logic    vsync;
        logic    de;
        logic    prev_bit;
        logic    grid;
    } pix_s;

    localparam pix_s PIX_IDLE = '{region: eRegNone, hsync: 1'b1, vsync: 1'b1,
                                  de: 1'b0, prev_bit: 1'b0, grid: 1'b0};

endpackage

// File: rtl/display_scanner_raster_timing.sv
// VGA-class raster counters: h/v position, active-low syncs, active window and frame start.
module raster_timing #(
    parameter int h_active_p = 640,
    parameter int h_fp_p     = 16,
    parameter int h_sync_p   = 96,
    parameter int h_bp_p     = 48,
    parameter int v_active_p = 480,
    parameter int v_fp_p     = 10,
    parameter int v_sync_p   = 2,
    parameter int v_bp_p     = 33
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic pix_en_i,
    output logic [$clog2(h_active_p+h_fp_p+h_sync_p+h_bp_p)-1:0] h_o,
    output logic [$clog2(v_active_p+v_fp_p+v_sync_p+v_bp_p)-1:0] v_o,
    output logic hsync_n_o,
    output logic vsync_n_o,
    output logic active_o,
    output logic frame_tick_o,
    output logic frame_start_o
);
    localparam int H_TOT = h_active_p + h_fp_p + h_sync_p + h_bp_p;
    localparam int V_TOT = v_active_p + v_fp_p + v_sync_p + v_bp_p;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(h_active_p);
    localparam logic [HW-1:0] HS_BEG = HW'(h_active_p + h_fp_p);
    localparam logic [HW-1:0] HS_END = HW'(h_active_p + h_fp_p + h_sync_p);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(v_active_p);
    localparam logic [VW-1:0] VS_BEG = VW'(v_active_p + v_fp_p);
    localparam logic [VW-1:0] VS_END = VW'(v_active_p + v_fp_p + v_sync_p);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          frame_start_q, frame_start_d;
    logic          at_origin;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            h_q           <= '0;
            v_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        at_origin     = (h_q == '0) && (v_q == '0);
        h_d           = h_q;
        v_d           = v_q;
        frame_start_d = frame_start_q;
        if (pix_en_i) begin
            // frame_start is registered so it lines up with the x/y stage
            frame_start_d = at_origin;
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_comb begin
        h_o           = h_q;
        v_o           = v_q;
        hsync_n_o     = !((h_q >= HS_BEG) && (h_q < HS_END));
        vsync_n_o     = !((v_q >= VS_BEG) && (v_q < VS_END));
        active_o      = (h_q < H_ACT) && (v_q < V_ACT);
        frame_tick_o  = pix_en_i && at_origin;
        frame_start_o = frame_start_q;
    end

endmodule

// File: rtl/display_scanner.sv
// Raster scan-out: walks the board via the game plate display port and emits 12-bit RGB.
// Optional build macro GRID_LINES_EN draws 12'h333 grid lines on empty board cells.
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int width_p    = 16,
    parameter int height_p   = 32,
    parameter int cell_lg_p  = 3,
    parameter int h_active_p = 640,
    parameter int h_fp_p     = 16,
    parameter int h_sync_p   = 96,
    parameter int h_bp_p     = 48,
    parameter int v_active_p = 480,
    parameter int v_fp_p     = 10,
    parameter int v_sync_p   = 2,
    parameter int v_bp_p     = 33,
    parameter int board_x0_p = 256,
    parameter int board_y0_p = 96,
    parameter int prev_x0_p  = 448,
    parameter int prev_y0_p  = 96,
    parameter int read_lat_p = 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        pix_en_i,
    output logic [$clog2(width_p)-1:0]  dis_logic_x_o,
    output logic [$clog2(height_p)-1:0] dis_logic_y_o,
    input  logic                        dis_logic_mm_i,
    input  logic                        dis_logic_cm_i,
    input  logic [3:0][3:0]             dis_logic_next_block_i,
    input  logic                        lose_i,
    output logic                        hsync_o,
    output logic                        vsync_o,
    output logic                        de_o,
    output logic [11:0]                 rgb_o,
    output logic                        frame_start_o
);
    localparam int XW    = $clog2(width_p);
    localparam int YW    = $clog2(height_p);
    localparam int H_TOT = h_active_p + h_fp_p + h_sync_p + h_bp_p;
    localparam int V_TOT = v_active_p + v_fp_p + v_sync_p + v_bp_p;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int D     = 1 + read_lat_p;

    localparam logic [HW:0] BRD_X0 = (HW+1)'(board_x0_p);
    localparam logic [HW:0] RNG_X0 = (HW+1)'(board_x0_p - 2);
    localparam logic [HW:0] PRV_X0 = (HW+1)'(prev_x0_p);
    localparam logic [HW:0] BRD_W  = (HW+1)'(width_p << cell_lg_p);
    localparam logic [HW:0] RNG_W  = (HW+1)'((width_p << cell_lg_p) + 4);
    localparam logic [HW:0] PRV_W  = (HW+1)'(4 << cell_lg_p);
    localparam logic [VW:0] BRD_Y0 = (VW+1)'(board_y0_p);
    localparam logic [VW:0] RNG_Y0 = (VW+1)'(board_y0_p - 2);
    localparam logic [VW:0] PRV_Y0 = (VW+1)'(prev_y0_p);
    localparam logic [VW:0] BRD_H  = (VW+1)'(height_p << cell_lg_p);
    localparam logic [VW:0] RNG_H  = (VW+1)'((height_p << cell_lg_p) + 4);
    localparam logic [VW:0] PRV_H  = (VW+1)'(4 << cell_lg_p);

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          hs_n, vs_n, active, frame_tick;

    raster_timing #(
        .h_active_p(h_active_p), .h_fp_p(h_fp_p), .h_sync_p(h_sync_p), .h_bp_p(h_bp_p),
        .v_active_p(v_active_p), .v_fp_p(v_fp_p), .v_sync_p(v_sync_p), .v_bp_p(v_bp_p)
    ) u_timing (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .pix_en_i     (pix_en_i),
        .h_o          (h),
        .v_o          (v),
        .hsync_n_o    (hs_n),
        .vsync_n_o    (vs_n),
        .active_o     (active),
        .frame_tick_o (frame_tick),
        .frame_start_o(frame_start_o)
    );

    // Offsets are one bit wider than the counters: a negative offset wraps
    // to a large unsigned value and fails the extent compare on its own.
    logic [HW:0]    bx, rx, px;
    logic [VW:0]    by, ry, py;
    logic           in_board, in_ring, in_prev;
    logic [1:0]     prev_r, prev_c;
    pix_s           pix_new;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic [3:0][3:0] prev_q, prev_d;
    pix_s           pipe_q [1:D];
    pix_s           pipe_d [1:D];
    pix_s           pix_out;

    always_comb begin
        bx       = {1'b0, h} - BRD_X0;
        rx       = {1'b0, h} - RNG_X0;
        px       = {1'b0, h} - PRV_X0;
        by       = {1'b0, v} - BRD_Y0;
        ry       = {1'b0, v} - RNG_Y0;
        py       = {1'b0, v} - PRV_Y0;
        in_board = (bx < BRD_W) && (by < BRD_H);
        in_ring  = (rx < RNG_W) && (ry < RNG_H);
        in_prev  = (px < PRV_W) && (py < PRV_H);
        prev_r   = py[cell_lg_p +: 2];
        prev_c   = px[cell_lg_p +: 2];

        pix_new.hsync    = hs_n;
        pix_new.vsync    = vs_n;
        pix_new.de       = active;
        pix_new.region   = in_board ? eRegBoard :
                           in_ring  ? eRegBorder :
                           in_prev  ? eRegPreview : eRegNone;
        pix_new.prev_bit = prev_q[prev_r][prev_c];
`ifdef GRID_LINES_EN
        pix_new.grid     = (bx[cell_lg_p-1:0] == '0) || (by[cell_lg_p-1:0] == '0);
`else
        pix_new.grid     = 1'b0;
`endif
    end

    always_comb begin
        pipe_d = pipe_q;
        x_d    = x_q;
        y_d    = y_q;
        prev_d = frame_tick ? dis_logic_next_block_i : prev_q;
        if (pix_en_i) begin
            pipe_d[1] = pix_new;
            for (int i = 2; i <= D; i++) pipe_d[i] = pipe_q[i-1];
            x_d = in_board ? bx[cell_lg_p +: XW] : '0;
            y_d = in_board ? by[cell_lg_p +: YW] : '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            x_q    <= '0;
            y_q    <= '0;
            prev_q <= '0;
            for (int i = 1; i <= D; i++) pipe_q[i] <= PIX_IDLE;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            prev_q <= prev_d;
            for (int i = 1; i <= D; i++) pipe_q[i] <= pipe_d[i];
        end
    end

    // The tail stage meets mm/cm as they arrive, so the colour mux stays combinational.
    always_comb begin
        pix_out = pipe_q[D];
        rgb_o   = COLOR_BLANK;
        if (pix_out.de) begin
            case (pix_out.region)
                eRegBoard: begin
                    if (dis_logic_cm_i)      rgb_o = COLOR_TILE;
                    else if (dis_logic_mm_i) rgb_o = lose_i ? COLOR_LOSE : COLOR_MM;
                    else                     rgb_o = pix_out.grid ? COLOR_GRID : COLOR_EMPTY;
                end
                eRegBorder:  rgb_o = COLOR_BORDER;
                eRegPreview: rgb_o = pix_out.prev_bit ? COLOR_PREV : COLOR_BLANK;
                default:     rgb_o = COLOR_BLANK;
            endcase
        end
    end

    always_comb begin
        dis_logic_x_o = x_q;
        dis_logic_y_o = y_q;
        hsync_o       = pix_out.hsync;
        vsync_o       = pix_out.vsync;
        de_o          = pix_out.de;
    end

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner on a shrunken raster (112x87) so whole frames stay short.
module tb_display_scanner;
    localparam int F = 112 * 87;

`ifdef GRID_LINES_EN
    localparam logic [11:0] GRID_EXP = 12'h333;
`else
    localparam logic [11:0] GRID_EXP = 12'h111;
`endif

    logic            clk = 1'b0;
    logic            reset_i, pix_en, mm_i, cm_i, lose, hsync_o, vsync_o, de_o, fs_o;
    logic [1:0]      x_o;
    logic [2:0]      y_o;
    logic [3:0][3:0] nb;
    logic [11:0]     rgb_o;

    int vectors = 0, miscompares = 0, ticks = 0;
    int hs_cnt, vs_cnt, de_cnt;
    logic [11:0] prev_rgb;
    logic [11:0] hr_exp [6] = '{12'h0AF, 12'h0AF, 12'hFFF, 12'hFFF, 12'h000, 12'h000};

    always #5 clk = ~clk;

    display_scanner #(
        .width_p(4), .height_p(8), .cell_lg_p(3),
        .h_active_p(96), .h_fp_p(4), .h_sync_p(8), .h_bp_p(4),
        .v_active_p(80), .v_fp_p(2), .v_sync_p(2), .v_bp_p(3),
        .board_x0_p(16), .board_y0_p(8), .prev_x0_p(56), .prev_y0_p(8),
        .read_lat_p(1)
    ) dut (
        .clk_i                 (clk),
        .reset_i               (reset_i),
        .pix_en_i              (pix_en),
        .dis_logic_x_o         (x_o),
        .dis_logic_y_o         (y_o),
        .dis_logic_mm_i        (mm_i),
        .dis_logic_cm_i        (cm_i),
        .dis_logic_next_block_i(nb),
        .lose_i                (lose),
        .hsync_o               (hsync_o),
        .vsync_o               (vsync_o),
        .de_o                  (de_o),
        .rgb_o                 (rgb_o),
        .frame_start_o         (fs_o)
    );

    // Game plate memory: one pix_en tick of read latency.
    always @(posedge clk) begin
        if (pix_en) begin
            mm_i <= (x_o == 2'd3 && y_o == 3'd7) || (x_o == 2'd1 && y_o == 3'd2);
            cm_i <= (x_o == 2'd1 && y_o == 3'd2);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic en);
        pix_en = en;
        @(posedge clk);
        #1;
        if (en) ticks++;
    endtask

    task automatic goto(input int t);
        while (ticks < t) cyc(1'b1);
    endtask

    initial begin
        reset_i = 1'b1; pix_en = 1'b1; lose = 1'b0; nb = 16'h0660; mm_i = 1'b0; cm_i = 1'b0;
        @(posedge clk); #1;
        chk("rst_hsync", hsync_o, 1); chk("rst_vsync", vsync_o, 1); chk("rst_de", de_o, 0);
        chk("rst_rgb", rgb_o, 0);     chk("rst_x", x_o, 0);         chk("rst_y", y_o, 0);
        chk("rst_fs", fs_o, 0);
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0; ticks = 0;

        cyc(1'b1); chk("fs_first", fs_o, 1);
        cyc(1'b1); chk("fs_drop", fs_o, 0); chk("de_p0", de_o, 1);

        hs_cnt = 0; vs_cnt = 0; de_cnt = 0;
        for (int i = 0; i < F; i++) begin
            if (i > 0) cyc(1'b1);
            if (i < 112 && !hsync_o) hs_cnt++;
            if (!vsync_o) vs_cnt++;
            if (de_o) de_cnt++;
        end
        chk("hsync_low_line", hs_cnt, 8);
        chk("vsync_low_frame", vs_cnt, 2 * 112);
        chk("de_frame", de_cnt, 96 * 80);

        // Frame 1: swap next block mid-preview, then walk the checked pixels in raster order.
        goto(F + 20 * 112); nb = 16'h0F00;
        goto(F + 28 * 112 + 28 + 2); chk("tile_over_mm", rgb_o, 12'hF80);
        goto(F + 28 * 112 + 60 + 2); chk("prev_old_c0", rgb_o, 12'h000);
        goto(F + 28 * 112 + 68 + 2); chk("prev_old_c1", rgb_o, 12'h0F0);
        goto(F + 35 * 112 + 32 + 2); chk("grid_edge", rgb_o, GRID_EXP);
        goto(F + 36 * 112 + 36 + 2); chk("empty_mid", rgb_o, 12'h111);
        goto(F + 40 * 112 + 14 + 2); chk("border_left", rgb_o, 12'hFFF);
        goto(F + 40 * 112 + 50 + 2); chk("past_border", rgb_o, 12'h000);
        goto(F + 64 * 112 + 45 + 1); chk("map_x", x_o, 3); chk("map_y", y_o, 7);
        cyc(1'b1); chk("map_rgb", rgb_o, 12'h0AF); chk("map_de", de_o, 1);
        lose = 1'b1; #1 chk("lose_rgb", rgb_o, 12'hF00);
        lose = 1'b0;
        goto(F + 64 * 112 + 100 + 2);
        chk("blank_de", de_o, 0); chk("blank_hsync", hsync_o, 0); chk("blank_rgb", rgb_o, 0);

        goto(2 * F + 1); chk("fs_frame2", fs_o, 1);
        goto(2 * F + 28 * 112 + 60 + 2); chk("prev_new_c0", rgb_o, 12'h0F0);

        // Half-rate enable across the right board edge and ring.
        goto(2 * F + 64 * 112 + 45 + 2);
        prev_rgb = 12'h0AF;
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0); chk("half_hold", rgb_o, prev_rgb); chk("half_hold_de", de_o, 1);
            cyc(1'b1); chk("half_pix", rgb_o, hr_exp[k]);
            prev_rgb = hr_exp[k];
        end

        #2 reset_i = 1'b1;
        #1;
        chk("midrst_hsync", hsync_o, 1); chk("midrst_vsync", vsync_o, 1);
        chk("midrst_de", de_o, 0);       chk("midrst_rgb", rgb_o, 0);
        repeat (2) @(posedge clk);
        #3 reset_i = 1'b0; ticks = 0;
        cyc(1'b1); chk("midrst_fs", fs_o, 1);
        cyc(1'b1); chk("midrst_fs_drop", fs_o, 0); chk("midrst_de_p0", de_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
